// File: rtl/led_matrix_column_scanner.sv
// Column scanner for the 5x7 irrigation-status LED matrix. It latches a coherent
// 35-bit frame once per scan and drives one column per slot. Each slot begins with
// a dark blanking gap to suppress ghosting. Every output is a register loaded from
// the next-state values, so the outputs change together with the state.
module led_matrix_column_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [34:0] col_rows_i,
  output logic [4:0]  matrix_cols_o,
  output logic [6:0]  matrix_rows_o,
  output logic [2:0]  col_index_o,
  output logic        frame_start_o
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] BlankLast = PreW'(BLANK_CYCLES - 1);
  localparam logic [PreW-1:0] DivLast   = PreW'(CLK_DIV - 1);
  localparam logic [2:0]      LastCol   = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StBlank, StDrive} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      idx_q, idx_d;
  logic [34:0]     frame_q, frame_d;

  logic [4:0]      cols_q, cols_d;
  logic [6:0]      rows_q, rows_d;
  logic [2:0]      colidx_q, colidx_d;
  logic            fs_q, fs_d;
  logic [6:0]      col_sel;

  // State, prescaler, column index and frame buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pre_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic. A low enable overrides everything, including the terminal count.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (!enable_i || (idx_q > LastCol)) begin
      // An index of 5..7 is unreachable. It is treated as corruption and sent back to idle.
      state_d = StIdle;
      pre_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StLoad;
          pre_d   = '0;
          idx_d   = '0;
        end
        StLoad: begin
          frame_d = col_rows_i;
          state_d = StBlank;
          pre_d   = '0;
          idx_d   = '0;
        end
        StBlank: begin
          // The prescaler keeps counting into DRIVE. The whole slot uses one count.
          pre_d = pre_q + 1'b1;
          if (pre_q == BlankLast) begin
            state_d = StDrive;
          end
        end
        StDrive: begin
          if (pre_q == DivLast) begin
            pre_d = '0;
            if (idx_q == LastCol) begin
              idx_d   = '0;
              state_d = StLoad;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StBlank;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          pre_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Select the buffered row image of the column that will be shown next.
  always_comb begin
    col_sel = 7'h00;
    case (idx_d)
      3'd0:    col_sel = frame_d[6:0];
      3'd1:    col_sel = frame_d[13:7];
      3'd2:    col_sel = frame_d[20:14];
      3'd3:    col_sel = frame_d[27:21];
      3'd4:    col_sel = frame_d[34:28];
      default: col_sel = 7'h00;
    endcase
  end

  // Output decode from the next-state values. The output registers then match the state registers.
  always_comb begin
    cols_d   = 5'b00000;
    rows_d   = 7'h7F;
    colidx_d = idx_d;
    fs_d     = (state_d == StLoad);
    if (state_d == StDrive) begin
      cols_d = 5'b00001 << idx_d;
      rows_d = ~col_sel;
    end
  end

  // Output registers. Reset darkens the matrix immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cols_q   <= 5'b00000;
      rows_q   <= 7'h7F;
      colidx_q <= 3'd0;
      fs_q     <= 1'b0;
    end else begin
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      colidx_q <= colidx_d;
      fs_q     <= fs_d;
    end
  end

  assign matrix_cols_o = cols_q;
  assign matrix_rows_o = rows_q;
  assign col_index_o   = colidx_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Scoreboard bench for led_matrix_column_scanner with CLK_DIV=4 and BLANK_CYCLES=1.
// The stimulus side predicts the timed frame_start and drive events of each frame.
// It computes them from the slot arithmetic and the image latched at LOAD. A monitor
// pops and compares an event whenever the DUT pulses frame_start or drives a column.
module tb_led_matrix_column_scanner;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Blank  = 1;
  localparam int          Fp     = 5 * ClkDiv + 1;
  localparam int          Never  = 32'h7fff_ffff;

  typedef struct {
    bit         fs;
    int         col;
    logic [6:0] rows;
    int         t;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [34:0] col_rows;
  logic [4:0]  matrix_cols;
  logic [6:0]  matrix_rows;
  logic [2:0]  col_index;
  logic        frame_start;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  q[$];
  logic [4:0] prev_cols = '0;

  led_matrix_column_scanner #(
    .CLK_DIV      (ClkDiv),
    .BLANK_CYCLES (Blank)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .col_rows_i    (col_rows),
    .matrix_cols_o (matrix_cols),
    .matrix_rows_o (matrix_rows),
    .col_index_o   (col_index),
    .frame_start_o (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endfunction

  // Expected events of one frame whose LOAD is seen at cycle b. Events after cycle last are cut off.
  task automatic push_frame(input int b, input logic [34:0] img, input int last);
    ev_t        e;
    logic [6:0] slice;
    if (b <= last) begin
      e = '{fs: 1'b1, col: 0, rows: 7'h7F, t: b};
      q.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      slice = img[7*k +: 7];
      for (int j = 0; j < int'(ClkDiv - Blank); j++) begin
        e = '{fs: 1'b0, col: k, rows: ~slice, t: b + 1 + int'(ClkDiv) * k + int'(Blank) + j};
        if (e.t <= last) q.push_back(e);
      end
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_scan(output int b);
    @(posedge clk);
    #1;
    enable = 1'b1;
    b = cyc + 1;
  endtask

  task automatic disable_at(input int d);
    wait_until(d);
    enable = 1'b0;
    wait_until(d + 1);
    check("off_cols", 32'(matrix_cols), 32'h0);
    check("off_rows", 32'(matrix_rows), 32'h7F);
    check("off_index", 32'(col_index), 32'h0);
    check("off_fs", 32'(frame_start), 32'h0);
  endtask

  function automatic logic [34:0] rnd35();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[34:0];
  endfunction

  // Monitor: checks the invariants every cycle and pops an expected event on each DUT event.
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_hot", 32'($countones(matrix_cols) <= 1), 32'h1);
      if (matrix_cols == 5'b0) check("dark_rows", 32'(matrix_rows), 32'h7F);
      if (matrix_cols != 5'b0 && prev_cols != 5'b0 && matrix_cols != prev_cols)
        check("blank_gap", 32'(matrix_cols), 32'(prev_cols));
      if (frame_start || matrix_cols != 5'b0) begin
        if (q.size() == 0) begin
          check("unexpected_event", {26'b0, frame_start, matrix_cols}, 32'h0);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("ev_time", 32'(cyc), 32'(e.t));
          check("ev_fs", 32'(frame_start), 32'(e.fs));
          check("ev_cols", 32'(matrix_cols), e.fs ? 32'h0 : 32'(5'b00001 << e.col));
          check("ev_rows", 32'(matrix_rows), 32'(e.rows));
          check("ev_index", 32'(col_index), 32'(e.col));
        end
      end
      prev_cols <= matrix_cols;
    end else begin
      prev_cols <= '0;
    end
  end

  initial begin
    int b;
    int b1;
    int b2;
    int d;
    logic [34:0] img;
    rst_n    = 1'b1;
    enable   = 1'b0;
    col_rows = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_cols", 32'(matrix_cols), 32'h0);
    check("rst_rows", 32'(matrix_rows), 32'h7F);
    check("rst_index", 32'(col_index), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_until(cyc + 4);
    check("idle_cols", 32'(matrix_cols), 32'h0);

    // Full scan with the fixed image; column 3 is rewritten while column 1 is driven.
    col_rows = {7'h41, 7'h3E, 7'h00, 7'h7F, 7'h01};
    start_scan(b);
    push_frame(b, col_rows, Never);
    wait_until(b + 7);
    col_rows[27:21] = 7'h7F;
    wait_until(b + Fp);
    b1 = b + Fp;
    push_frame(b1, col_rows, b1 + 11);
    // Disable during the column 2 drive.
    disable_at(b1 + 11);
    wait_until(cyc + 3);
    // Re-enable restarts with LOAD, then column 0.
    start_scan(b2);
    push_frame(b2, col_rows, b2 + 4);
    disable_at(b2 + 4);
    wait_until(cyc + 3);

    // Random images and mid-frame rewrites. Even rounds end on the column 4 terminal count.
    for (int i = 0; i < 6; i++) begin
      col_rows = rnd35();
      start_scan(b);
      push_frame(b, col_rows, Never);
      wait_until(b + int'($urandom_range(1, Fp - 1)));
      col_rows = rnd35();
      wait_until(b + Fp);
      b2 = b + Fp;
      d = (i % 2 == 0) ? b2 + Fp - 1 : b2 + int'($urandom_range(0, Fp - 1));
      push_frame(b2, col_rows, d);
      disable_at(d);
      wait_until(cyc + 5);
    end

    // Asynchronous reset during the column 2 drive.
    col_rows = rnd35();
    img = col_rows;
    start_scan(b);
    push_frame(b, img, b + 9);
    wait_until(b + 10);
    check("pre_rst_cols", 32'(matrix_cols), 32'h4);
    rst_n = 1'b0;
    #1;
    check("arst_cols", 32'(matrix_cols), 32'h0);
    check("arst_rows", 32'(matrix_rows), 32'h7F);
    check("arst_index", 32'(col_index), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_until(cyc + 5);

    check("queue_drain", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_matrix_column_scanner.md
# led_matrix_column_scanner

Time-multiplexed driver for the 5x7 LED matrix that shows irrigation status. It sits directly downstream of the five per-column irrigation status decoders. It takes their 7-bit row images, latches them once per frame so each frame is coherent, and scans the columns one at a time. A blanking gap between columns suppresses ghosting.

## Interface
- `CLK_DIV`, default 50000: clock cycles per column slot, including blanking; must be at least 2.
- `BLANK_CYCLES`, default 2: cycles at the start of each slot with the matrix dark; must be at least 1 and less than `CLK_DIV`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  scanning enable; low forces the matrix dark.
- `col_rows`  in  35  packed decoder outputs.
  - Column k occupies bits [7k+6:7k].
  - Bit r = 1 means row r is lit.
- `matrix_cols`  out  5  column drive, one-hot, active-high.
- `matrix_rows`  out  7  row drive, active-low: 0 = LED on.
- `col_index`  out  3  column currently in its slot, 0..4.
- `frame_start`  out  1  one-cycle pulse while a new frame is being latched.

## Operation
- FSM states are IDLE, LOAD, BLANK and DRIVE. All outputs are registers decoded from the registered state, prescaler, column index and frame buffer.
- IDLE
  - Prescaler = 0, column index = 0.
  - Outputs dark: `matrix_cols` = 5'b00000, `matrix_rows` = 7'h7F.
  - `enable` = 1 moves to LOAD.
- LOAD (exactly 1 cycle)
  - `frame_start` = 1 and outputs are dark.
  - On the exiting edge, the 35-bit frame buffer captures `col_rows`.
  - Next state is BLANK with prescaler = 0 and column index = 0.
- BLANK
  - Outputs dark; `col_index` shows the pending column.
  - Prescaler increments each cycle.
  - When prescaler reaches `BLANK_CYCLES`-1, move to DRIVE.
- DRIVE
  - `matrix_cols` = one-hot of `col_index`.
  - `matrix_rows` = bitwise NOT of the buffered column `col_index`.
  - Prescaler increments each cycle.
  - When prescaler reaches `CLK_DIV`-1:
    - Prescaler goes to 0.
    - If column index = 4, wrap to 0 and go to LOAD.
    - Otherwise increment column index and go to BLANK.
- Frame buffer behaviour:
  - `col_rows` changes mid-frame are invisible until the next LOAD.
  - The buffer is never updated outside LOAD.
- Width rules:
  - The prescaler is wide enough for `CLK_DIV`-1; $clog2(CLK_DIV) bits, minimum 1.
  - The column index is 3 bits and never exceeds 4. The values 5..7 are unreachable; if forced, recover to IDLE.
- `enable` low
  - Sampled low in any state, the next state is IDLE.
  - Outputs go dark on that same edge; prescaler and index clear.
  - The frame buffer keeps its contents but is reloaded on the next LOAD.
- Simultaneous events: `enable` low at the DRIVE terminal count wins, so the next state is IDLE, not LOAD or BLANK.
- Reset
  - `rst_n` low asynchronously forces state IDLE, prescaler 0, index 0 and frame buffer 0.
  - Outputs take their reset values immediately, including mid-frame: `matrix_cols` = 0, `matrix_rows` = 7'h7F, `col_index` = 0, `frame_start` = 0.

## Timing
- The first edge with `enable` = 1 in IDLE enters LOAD; `frame_start` is high for the following cycle.
- `col_rows` is sampled at the edge that ends LOAD, i.e. one cycle after `frame_start` rises.
- Each column slot is `CLK_DIV` cycles: `BLANK_CYCLES` dark, then `CLK_DIV`-`BLANK_CYCLES` driven.
- Frame period = 5·`CLK_DIV` + 1 cycles, counted from LOAD to the next LOAD.
- At most one bit of `matrix_cols` is high at any time. Between consecutive driven columns, all bits are low for at least `BLANK_CYCLES` cycles.
- From `enable` low to dark outputs: 1 edge.

## Test plan
All scenarios use `CLK_DIV`=4 and `BLANK_CYCLES`=1.
- Reset: hold `rst_n`=0 mid-DRIVE -> `matrix_cols`=0, `matrix_rows`=7'h7F and `col_index`=0 without waiting for a clock edge.
- Full scan: `col_rows` = {7'h41, 7'h3E, 7'h00, 7'h7F, 7'h01} (column 4 first), `enable`=1.
  - `frame_start` pulses once.
  - Columns 0..4 are each driven for 3 cycles with `matrix_rows` = 7'h7E, 7'h00, 7'h7F, 7'h41, 7'h3E.
  - Each driven window is preceded by 1 dark cycle.
  - The next `frame_start` arrives exactly 21 cycles after the first.
- Coherence: change `col_rows` column 3 from 7'h3E to 7'h7F while column 1 is driven.
  - Column 3 still shows `matrix_rows`=7'h41 in the current frame.
  - It shows 7'h00 in the next frame.
- Disable mid-slot: drop `enable` during column 2 DRIVE.
  - Dark on the next edge; `col_index`=0.
  - Re-enable restarts with LOAD, then column 0.
- Terminal collision: deassert `enable` exactly on the column 4 terminal-count cycle -> IDLE, no `frame_start` pulse.
- Invariant check throughout all runs: `matrix_cols` is never multi-hot, and `matrix_rows`=7'h7F whenever `matrix_cols`=0.
